seg_scan_decoder: RTL
=====================

# seg_scan_decoder

Recovers BCD digit values from a time-multiplexed, active-high 7-segment display drive (one-hot digit select plus shared segment lines), performing the inverse of the team's BCD-to-segment decoder. It sits on the observation side of display bring-up and self-check: it captures what a scanned display is actually showing and reports each digit change through a single-entry valid/ready update port. Per-digit stability filtering rejects scan-transition glitches.

## Interface
- DIGITS, 4, number of scanned digit positions (1..8)
- STABLE_CNT, 3, consecutive identical samples of a digit required to commit (1..15)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- dig_sel  in  DIGITS  one-hot digit enable, bit i = digit i
- seg_in  in  7  segments {a,b,c,d,e,f,g}, seg_in[6]=a, active-high
- clr_err  in  1  clears sticky err, sel_err, ovf
- upd_ready  in  1  consumer accepts update
- bcd_out  out  4*DIGITS  committed code per digit, digit i at [4i+3:4i]
- digit_valid  out  DIGITS  digit i has committed at least once
- upd_valid  out  1  update pending
- upd_idx  out  3  digit index of pending update
- upd_bcd  out  4  code of pending update
- err  out  1  sticky: an unrecognised pattern was committed
- sel_err  out  1  sticky: dig_sel had more than one bit set
- ovf  out  1  sticky: an update was dropped

## Operation
- Input stage registers dig_sel and seg_in every cycle.
- Sample: registered dig_sel exactly one-hot. All-zero: ignored, no flag. Multi-hot: ignored, sel_err set.
- Decode table ({a..g} -> code): 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1111011->9; any other pattern -> 4'hE.
- Per digit: candidate pattern + counter (4 bits, saturating at STABLE_CNT). Sample equal to candidate: counter increments. Different: candidate replaced, counter = 1.
- Commit on the sample where counter becomes equal to STABLE_CNT (not while saturated). Commit writes code to bcd_out slice, sets digit_valid bit; code 4'hE also sets err.
- Update generated on commit when code differs from stored value or digit_valid bit was 0.
- Update port: idle -> load {idx, code}, upd_valid=1. Held stable until upd_ready=1 at a clock edge, then upd_valid=0. New update while upd_valid=1 and upd_ready=0: new update dropped, ovf set; bcd_out still updated.
- Accept and new update on same edge: new update loaded, upd_valid stays 1, no ovf.
- clr_err clears all three sticky flags; a flag-setting event on the same edge wins (flag reads 1).
- Only one digit is sampled per cycle, so at most one commit per cycle.

## Timing
- Reset values: bcd_out all 4'hF, digit_valid 0, upd_valid 0, upd_idx 0, upd_bcd 0, err 0, sel_err 0, ovf 0; all candidates cleared (pattern 0, counter 0).
- Latency: inputs at edge k are registered at edge k; a committing sample updates bcd_out, digit_valid, err, and upd_* at edge k+1 (two edges from pin to output).
- sel_err visible after edge k+1 for a multi-hot dig_sel registered at edge k.
- Reset asserted mid-operation: all state returns to reset values immediately; pending update is discarded.
- Counters never wrap; saturation holds the committed value without regenerating updates.

## Configuration
- SEG_BLANK_EN defined: pattern 0000000 decodes to 4'hF (blank), is a normal valid code, and does not set err.
- SEG_BLANK_EN undefined: 0000000 decodes to 4'hE and sets err on commit.

## Test plan
- Reset with arbitrary inputs -> all outputs at listed reset values; bcd_out = 16'hFFFF for DIGITS=4.
- dig_sel=0001, seg_in=0110000 for 3 cycles -> two edges later bcd_out[3:0]=1, digit_valid=0001, upd_valid=1, upd_idx=0, upd_bcd=1; after only 2 samples -> no change.
- Digit 2: two samples of 1111111, one of 1111011, then three of 1111011 -> single commit of 9, no commit of 8; repeated 9 samples -> no further update.
- upd_ready=0; digit 0 commits 3, then digit 1 commits 5 -> upd_idx=0, upd_bcd=3 held, ovf=1, bcd_out[7:4]=5; upd_ready=1 -> upd_valid drops next edge.
- Digit 1 stable on 0000001 -> code E, err=1; dig_sel=0011 -> sel_err=1, no commit; clr_err pulse -> all flags 0.
- Digit 3 stable on 0000000 -> code F with err=0 when SEG_BLANK_EN is defined; code E with err=1 when it is undefined.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - scanned 7-segment observer recovering per-digit BCD codes; optional feature macro SEG_BLANK_EN
module seg_scan_decoder #(
  parameter int DIGITS     = 4,
  parameter int STABLE_CNT = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DIGITS-1:0]   dig_sel,
  input  logic [6:0]          seg_in,
  input  logic                clr_err,
  input  logic                upd_ready,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic [DIGITS-1:0]   digit_valid,
  output logic                upd_valid,
  output logic [2:0]          upd_idx,
  output logic [3:0]          upd_bcd,
  output logic                err,
  output logic                sel_err,
  output logic                ovf
);

  localparam logic [3:0] STABLE   = 4'(STABLE_CNT);
  localparam logic [3:0] CODE_ERR = 4'hE;

  typedef enum logic {UPD_IDLE, UPD_PEND} upd_state_t;

  logic [DIGITS-1:0] sel_q;
  logic [6:0]        seg_q;
  logic [6:0]        cand [DIGITS];
  logic [3:0]        cnt  [DIGITS];
  upd_state_t        upd_state, upd_state_nxt;

  logic       sel_multi, sample_ok;
  logic [2:0] cur_idx;
  logic [6:0] cur_cand;
  logic [3:0] cur_cnt, cur_bcd, cnt_nxt, code;
  logic       cur_valid, seg_match, commit, new_upd, load_upd, drop_upd;

  // Register the raw display drive once per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= '0;
      seg_q <= '0;
    end else begin
      sel_q <= dig_sel;
      seg_q <= seg_in;
    end
  end

  // Qualify the sample and pull out the addressed digit's tracking state
  always_comb begin
    sel_multi = (sel_q & (sel_q - DIGITS'(1))) != '0;
    sample_ok = (sel_q != '0) && !sel_multi;
    cur_idx   = 3'd0;
    cur_cand  = 7'd0;
    cur_cnt   = 4'd0;
    cur_bcd   = 4'd0;
    cur_valid = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel_q[i]) begin
        cur_idx   = 3'(i);
        cur_cand  = cand[i];
        cur_cnt   = cnt[i];
        cur_bcd   = bcd_out[4*i +: 4];
        cur_valid = digit_valid[i];
      end
    end
  end

  // Segment pattern to code lookup
  always_comb begin
    case (seg_q)
      7'b1111110: code = 4'd0;
      7'b0110000: code = 4'd1;
      7'b1101101: code = 4'd2;
      7'b1111001: code = 4'd3;
      7'b0110011: code = 4'd4;
      7'b1011011: code = 4'd5;
      7'b1011111: code = 4'd6;
      7'b1110000: code = 4'd7;
      7'b1111111: code = 4'd8;
      7'b1111011: code = 4'd9;
`ifdef SEG_BLANK_EN
      7'b0000000: code = 4'hF;
`else
      7'b0000000: code = CODE_ERR;
`endif
      default:    code = CODE_ERR;
    endcase
  end

  // Stability counter step; commit only on the sample that reaches the threshold
  always_comb begin
    seg_match = (seg_q == cur_cand);
    if (!seg_match)             cnt_nxt = 4'd1;
    else if (cur_cnt == STABLE) cnt_nxt = cur_cnt;
    else                        cnt_nxt = cur_cnt + 4'd1;
    commit  = sample_ok && (cnt_nxt == STABLE) && !(seg_match && (cur_cnt == STABLE));
    new_upd = commit && (!cur_valid || (cur_bcd != code));
  end

  // Per-digit candidate tracking and committed display value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIGITS; i++) begin
        cand[i] <= 7'd0;
        cnt[i]  <= 4'd0;
      end
      bcd_out     <= '1;
      digit_valid <= '0;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (sample_ok && sel_q[i]) begin
          cand[i] <= seg_q;
          cnt[i]  <= cnt_nxt;
          if (commit) begin
            bcd_out[4*i +: 4] <= code;
            digit_valid[i]    <= 1'b1;
          end
        end
      end
    end
  end

  // Update port state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) upd_state <= UPD_IDLE;
    else        upd_state <= upd_state_nxt;
  end

  // Update port next state: an accept frees the slot for a same-edge update
  always_comb begin
    upd_state_nxt = upd_state;
    load_upd      = 1'b0;
    drop_upd      = 1'b0;
    case (upd_state)
      UPD_IDLE: begin
        if (new_upd) begin
          load_upd      = 1'b1;
          upd_state_nxt = UPD_PEND;
        end
      end
      UPD_PEND: begin
        if (upd_ready) begin
          if (new_upd) load_upd      = 1'b1;
          else         upd_state_nxt = UPD_IDLE;
        end else if (new_upd) begin
          drop_upd = 1'b1;
        end
      end
      default: upd_state_nxt = UPD_IDLE;
    endcase
  end

  assign upd_valid = (upd_state == UPD_PEND);

  // Update payload, held stable while pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_idx <= 3'd0;
      upd_bcd <= 4'd0;
    end else if (load_upd) begin
      upd_idx <= cur_idx;
      upd_bcd <= code;
    end
  end

  // Sticky flags; a same-edge setting event beats clr_err
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err     <= 1'b0;
      sel_err <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      err     <= (err & ~clr_err) | (commit && (code == CODE_ERR));
      sel_err <= (sel_err & ~clr_err) | sel_multi;
      ovf     <= (ovf & ~clr_err) | drop_upd;
    end
  end

endmodule
